// File: rtl/ps2_jump_rx_pkg.sv
// Shared types and constants for the PS/2 jump receiver: receiver state
// encoding, scan-code prefixes and the default jump key.
package ps2_jump_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] PS2_BREAK         = 8'hF0;
  localparam logic [7:0] PS2_EXTEND        = 8'hE0;
  localparam logic [7:0] JUMP_CODE_DEFAULT = 8'h29;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, ps2_clk glitch filter, 11-bit
// frame FSM with parity/stop checking and an idle-clock timeout.
module ps2_frame_rx
  import ps2_jump_rx_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned     FILT_W    = $clog2(FILTER_LEN + 1);
  localparam int unsigned     TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        clk_sync_q, data_sync_q;
  logic              filt_q, filt_d, filt_prev_q;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              strobe_s, data_s;

  rx_state_e         state_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic              par_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q, frame_err_q;

  // Filtered clock only follows the synchronized line after FILTER_LEN disagreeing samples in a row.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = filt_cnt_q;
    if (clk_sync_q[1] == filt_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_LAST) begin
      filt_d     = clk_sync_q[1];
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + FILT_W'(1);
    end
  end

  // Synchronizers and filter state; idle PS/2 lines are high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      filt_cnt_q  <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  assign strobe_s = filt_prev_q & ~filt_q;
  assign data_s   = data_sync_q[1];

  // Frame FSM with registered result pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (state_q == ST_IDLE) begin
        to_cnt_q <= '0;
        if (strobe_s && !data_s) begin
          state_q   <= ST_DATA;
          shift_q   <= 8'h00;
          bit_cnt_q <= 3'd0;
        end
      end else if (strobe_s) begin
        to_cnt_q <= '0;
        case (state_q)
          ST_DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_q   <= data_s;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (data_s && odd_parity_ok(shift_q, par_q)) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (to_cnt_q == TO_LAST) begin
        // Keyboard went quiet mid-frame: drop the partial byte.
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
        to_cnt_q    <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/ps2_jump_rx.sv
// PS/2 keyboard jump input: decodes space-bar make/break codes into key_held
// and merges them with the board pushbutton into a per-frame jump request.
module ps2_jump_rx
  import ps2_jump_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [7:0]  JUMP_CODE      = JUMP_CODE_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       jump_i,
  input  logic       screen_end_i,
  output logic       button_press_o,
  output logic       key_held_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);

  // A zero timeout selects 2 ms derived from the clock frequency.
  localparam int unsigned TIMEOUT_EFF = (TIMEOUT_CYCLES == 0) ? (CLK_HZ / 500) : TIMEOUT_CYCLES;

  logic [7:0] rx_data_s;
  logic       rx_valid_s;
  logic [1:0] jump_sync_q;
  logic       jump_prev_q;
  logic       brk_q, brk_d, ext_q, ext_d;
  logic       key_held_q, key_held_d, key_prev_q;
  logic       button_press_q, button_press_d;
  logic       set_s;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_EFF)
  ) u_frame_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .rx_data_o   (rx_data_s),
    .rx_valid_o  (rx_valid_s),
    .frame_err_o (frame_err_o)
  );

  // Scan-code decoder: prefixes arm flags, any other byte consumes them.
  always_comb begin
    brk_d      = brk_q;
    ext_d      = ext_q;
    key_held_d = key_held_q;
    if (rx_valid_s) begin
      if (rx_data_s == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_data_s == PS2_EXTEND) begin
        ext_d = 1'b1;
      end else begin
        if ((rx_data_s == JUMP_CODE) && !ext_q) begin
          key_held_d = ~brk_q;
        end else begin
          key_held_d = key_held_q;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end else begin
      key_held_d = key_held_q;
    end
  end

  // Only rising edges request a jump, so typematic repeats are ignored.
  assign set_s = (key_held_q & ~key_prev_q) | (jump_sync_q[1] & ~jump_prev_q);

  // Jump latch: a set event beats the end-of-frame clear.
  always_comb begin
    button_press_d = button_press_q;
    if (set_s) begin
      button_press_d = 1'b1;
    end else if (screen_end_i) begin
      button_press_d = 1'b0;
    end else begin
      button_press_d = button_press_q;
    end
  end

  // Decoder, pushbutton synchronizer and latch state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      jump_sync_q    <= 2'b00;
      jump_prev_q    <= 1'b0;
      brk_q          <= 1'b0;
      ext_q          <= 1'b0;
      key_held_q     <= 1'b0;
      key_prev_q     <= 1'b0;
      button_press_q <= 1'b0;
    end else begin
      jump_sync_q    <= {jump_sync_q[0], jump_i};
      jump_prev_q    <= jump_sync_q[1];
      brk_q          <= brk_d;
      ext_q          <= ext_d;
      key_held_q     <= key_held_d;
      key_prev_q     <= key_held_q;
      button_press_q <= button_press_d;
    end
  end

  assign button_press_o = button_press_q;
  assign key_held_o     = key_held_q;
  assign rx_data_o      = rx_data_s;
  assign rx_valid_o     = rx_valid_s;

endmodule

// File: tb/tb_ps2_jump_rx.sv
// Randomized PS/2 frame bench for ps2_jump_rx, checked against a byte-level
// model of the scan-code decoder and jump latch.
module tb_ps2_jump_rx;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       jump = 1'b0;
  logic       screen_end = 1'b0;
  logic       button_press, key_held, rx_valid, frame_err;
  logic [7:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;

  int v_cnt = 0, e_cnt = 0, both_cnt = 0;

  logic       m_brk = 1'b0, m_ext = 1'b0, m_key = 1'b0, m_bp = 1'b0;
  logic [7:0] m_rx_data = 8'h00;

  ps2_jump_rx #(
    .CLK_HZ         (100_000_000),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TIMEOUT),
    .JUMP_CODE      (8'h29)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ps2_clk_i      (ps2_clk),
    .ps2_data_i     (ps2_data),
    .jump_i         (jump),
    .screen_end_i   (screen_end),
    .button_press_o (button_press),
    .key_held_o     (key_held),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .frame_err_o    (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) v_cnt++;
    if (frame_err) e_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Device-side PS/2 transmit: data set while clock high, sampled on falling edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic was_held;
    was_held  = m_key;
    m_rx_data = b;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else begin
      if (b == 8'h29 && !m_ext) begin
        if (m_brk) m_key = 1'b0;
        else m_key = 1'b1;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    if (m_key && !was_held) m_bp = 1'b1;
  endtask

  task automatic do_frame(input string tag, input logic [7:0] b, input logic bad_par, input logic bad_stop);
    int   v0, e0;
    logic par;
    v0  = v_cnt;
    e0  = e_cnt;
    par = (~^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    repeat (3 * HALF) @(negedge clk);
    if (!bad_par && !bad_stop) model_byte(b);
    check($sformatf("%s.valid", tag), v_cnt - v0, (bad_par || bad_stop) ? 0 : 1);
    check($sformatf("%s.err", tag), e_cnt - e0, (bad_par || bad_stop) ? 1 : 0);
    check($sformatf("%s.rx_data", tag), rx_data, m_rx_data);
    check($sformatf("%s.key_held", tag), key_held, m_key);
    check($sformatf("%s.button", tag), button_press, m_bp);
  endtask

  task automatic pulse_screen_end(input string tag);
    @(negedge clk);
    screen_end = 1'b1;
    @(negedge clk);
    screen_end = 1'b0;
    m_bp = 1'b0;
    check(tag, button_press, m_bp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0;
    logic [7:0] b;
    int kind;
    logic bad_par, bad_stop;

    repeat (5) @(negedge clk);
    check("rst.button", button_press, 1'b0);
    check("rst.key_held", key_held, 1'b0);
    check("rst.rx_data", rx_data, 8'h00);
    check("rst.valid", rx_valid, 1'b0);
    check("rst.err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    do_frame("make", 8'h29, 1'b0, 1'b0);
    pulse_screen_end("clear");
    do_frame("typematic", 8'h29, 1'b0, 1'b0);
    do_frame("brk_pfx", 8'hF0, 1'b0, 1'b0);
    do_frame("brk_key", 8'h29, 1'b0, 1'b0);
    do_frame("bad_par", 8'h29, 1'b1, 1'b0);

    // Partial frame then silence must be abandoned by the timeout.
    v0 = v_cnt;
    e0 = e_cnt;
    send_bits({6'b0, 4'h9, 1'b0}, 5);
    repeat (TIMEOUT - 40) @(negedge clk);
    check("to.early", e_cnt - e0, 0);
    for (int i = 0; i < 120 && e_cnt == e0; i++) @(negedge clk);
    check("to.err", e_cnt - e0, 1);
    check("to.valid", v_cnt - v0, 0);
    do_frame("after_to", 8'h1C, 1'b0, 1'b0);

    // Pushbutton rise vs end-of-frame clear at edges 1..5; set lands on edge 3.
    for (int e = 1; e <= 5; e++) begin
      jump = 1'b0;
      repeat (6) @(negedge clk);
      for (int k = 1; k <= 6; k++) begin
        jump       = 1'b1;
        screen_end = (k == e);
        @(negedge clk);
      end
      screen_end = 1'b0;
      repeat (3) @(negedge clk);
      m_bp = (e <= 3);
      check($sformatf("jump_se%0d", e), button_press, m_bp);
    end
    jump = 1'b0;
    repeat (6) @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) b = 8'h29;
      else if (kind == 4) b = 8'hF0;
      else if (kind == 5) b = 8'hE0;
      else b = 8'($urandom_range(0, 255));
      bad_par  = ($urandom_range(0, 7) == 0);
      bad_stop = !bad_par && ($urandom_range(0, 9) == 0);
      do_frame($sformatf("rnd%0d_%02h", n, b), b, bad_par, bad_stop);
      if ($urandom_range(0, 2) == 0) pulse_screen_end($sformatf("rnd%0d.clear", n));
    end

    // Asynchronous reset in the middle of a data byte.
    do_frame("pre_rst_a", 8'h1C, 1'b0, 1'b0);
    do_frame("pre_rst_b", 8'h29, 1'b0, 1'b0);
    send_bits({6'b0, 4'h9, 1'b0}, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.button", button_press, 1'b0);
    check("arst.key_held", key_held, 1'b0);
    check("arst.rx_data", rx_data, 8'h00);
    check("arst.valid", rx_valid, 1'b0);
    check("arst.err", frame_err, 1'b0);
    m_brk = 1'b0; m_ext = 1'b0; m_key = 1'b0; m_bp = 1'b0; m_rx_data = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_frame("post_rst", 8'h29, 1'b0, 1'b0);

    check("valid_err_overlap", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
